uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises one word per frame:

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_cfg.sv | 117 +++++++++++
 tb/tb_uart_tx_cfg.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART transmitter: parity modes,
// FSM state encoding and the frame length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int frame_bits(int data_bits, int parity, int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLOCKS_PER_BAUD-1 and pulses stb on the top value.
// restart zeroes the count so bit phase follows the frame start.
module uart_baud_gen #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic stb
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLOCKS_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_TOP)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stb = (cnt == CNT_TOP);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, DATA_BITS data LSB-first, optional
// parity, 1-2 stop bits. o_tx is registered and idles high.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_tx,
  output logic [2:0]           dbg_state
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  generate
    if (CLOCKS_PER_BAUD < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FRAME_BITS > 13) begin : g_bad_params
      $fatal(1, "uart_tx_cfg: illegal parameter set");
    end
  endgenerate

  logic [2:0]           state, next_state;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_idx;
  logic                 par_bit, stop_cnt, tx_q, stb, accept, last_data, last_stop;

  // Handshake: a word transfers on any posedge where i_valid && o_ready.
  // o_ready never depends on i_valid; i_valid without o_ready is simply ignored.
  assign accept    = i_valid && o_ready;
  assign last_data = (bit_idx == DATA_LAST);
  assign last_stop = (stop_cnt == STOP_LAST);
  assign o_tx      = tx_q;

  uart_baud_gen #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .stb     (stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_START;
      ST_START:  if (stb) next_state = ST_DATA;
      ST_DATA:   if (stb && last_data) next_state = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (stb) next_state = ST_STOP;
      ST_STOP: begin
        if (accept)                 next_state = ST_START;
        else if (stb && last_stop)  next_state = ST_IDLE;
      end
      default:   next_state = ST_IDLE;
    endcase
  end

  // Ready in the last clk of the last stop bit lets the next frame start with no gap.
  always_comb begin
    o_ready   = (state == ST_IDLE) || ((state == ST_STOP) && last_stop && stb);
    o_busy    = (state != ST_IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '1;
      par_bit  <= 1'b1;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
    end else if (accept) begin
      shreg    <= i_data;
      par_bit  <= (PARITY == PARITY_ODD) ? ~^i_data : ^i_data;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b0;
    end else if (stb) begin
      case (state)
        ST_START: begin
          tx_q  <= shreg[0];
          shreg <= {1'b1, shreg[DATA_BITS-1:1]};
        end
        ST_DATA: begin
          if (last_data) begin
            tx_q <= (PARITY != PARITY_NONE) ? par_bit : 1'b1;
          end else begin
            tx_q    <= shreg[0];
            shreg   <= {1'b1, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: tx_q <= 1'b1;
        ST_STOP: begin
          tx_q <= 1'b1;
          if (!last_stop) stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at 4 clks/bit,
// checked every clk against a frame-level line model plus an 8N1 line decoder.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valid_w;
  logic [8:0] din [4];
  logic [3:0] tx_w, rdy_w, bsy_w;
  logic [2:0] st_w [4];

  int n_checks = 0;
  int n_errors = 0;

  int db_c[4]   = '{8, 8, 8, 7};
  int par_c[4]  = '{0, 2, 1, 0};
  int stop_c[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .i_valid(valid_w[0]), .i_data(din[0][7:0]),
    .o_ready(rdy_w[0]), .o_busy(bsy_w[0]), .o_tx(tx_w[0]), .dbg_state(st_w[0]));
  uart_tx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .i_valid(valid_w[1]), .i_data(din[1][7:0]),
    .o_ready(rdy_w[1]), .o_busy(bsy_w[1]), .o_tx(tx_w[1]), .dbg_state(st_w[1]));
  uart_tx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .i_valid(valid_w[2]), .i_data(din[2][7:0]),
    .o_ready(rdy_w[2]), .o_busy(bsy_w[2]), .o_tx(tx_w[2]), .dbg_state(st_w[2]));
  uart_tx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .i_valid(valid_w[3]), .i_data(din[3][6:0]),
    .o_ready(rdy_w[3]), .o_busy(bsy_w[3]), .o_tx(tx_w[3]), .dbg_state(st_w[3]));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line bits of one frame, index 0 = start bit.
  function automatic void frame_of(input int u, input logic [8:0] d,
                                   output logic [15:0] bits, output int len);
    int   pos;
    logic p;
    bits    = '1;
    bits[0] = 1'b0;
    pos     = 1;
    p       = 1'b0;
    for (int i = 0; i < db_c[u]; i++) begin
      bits[pos] = d[i];
      p         = p ^ d[i];
      pos++;
    end
    if (par_c[u] != 0) begin
      bits[pos] = (par_c[u] == 1) ? ~p : p;
      pos++;
    end
    len = pos + stop_c[u];
  endfunction

  // Line model: a frame accepted at the posedge before negedge n drives bit k
  // during negedges n + k*CPB .. n + k*CPB + CPB-1.
  int          cyc = 0;
  int          f_start[4];
  int          f_len[4];
  logic [15:0] f_bits[4];
  bit          f_on[4]    = '{0, 0, 0, 0};
  bit          rdy_exp[4] = '{1, 1, 1, 1};
  logic [7:0]  exp_q[$];

  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 4; u++) begin
      int   j;
      logic etx;
      if (reset) begin
        f_on[u]    = 1'b0;
        rdy_exp[u] = 1'b1;
        if (u == 0) exp_q.delete();
        chk($sformatf("reset_tx[%0d]", u), tx_w[u], 1);
        chk($sformatf("reset_ready[%0d]", u), rdy_w[u], 1);
        chk($sformatf("reset_busy[%0d]", u), bsy_w[u], 0);
      end else begin
        if (valid_w[u] && rdy_exp[u]) begin
          frame_of(u, din[u], f_bits[u], f_len[u]);
          f_start[u] = cyc;
          f_on[u]    = 1'b1;
          if (u == 0) exp_q.push_back(din[0][7:0]);
        end
        j = cyc - f_start[u];
        if (f_on[u] && j >= f_len[u] * CPB) f_on[u] = 1'b0;
        etx = f_on[u] ? f_bits[u][j / CPB] : 1'b1;
        rdy_exp[u] = !f_on[u] || (j == f_len[u] * CPB - 1);
        chk($sformatf("tx[%0d]", u), tx_w[u], etx);
        chk($sformatf("ready[%0d]", u), rdy_w[u], rdy_exp[u]);
        chk($sformatf("busy[%0d]", u), bsy_w[u], f_on[u]);
      end
    end
  end

  // Independent 8N1 decoder on DUT 0, sampling mid-bit; words go to the scoreboard.
  bit         dec_on = 1'b0;
  int         dec_cnt;
  logic [7:0] dec_word;

  always @(negedge clk) begin
    if (reset) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (tx_w[0] == 1'b0) begin
        dec_on  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if ((dec_cnt % CPB == CPB / 2) && (dec_cnt / CPB >= 1) && (dec_cnt / CPB <= 8))
        dec_word[dec_cnt / CPB - 1] = tx_w[0];
      if (dec_cnt == 9 * CPB + CPB / 2) begin
        chk("dec_stop_bit", tx_w[0], 1);
        chk("dec_word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("dec_word", dec_word, exp_q.pop_front());
      end
      if (dec_cnt == 10 * CPB - 1) dec_on = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bsy_w != 4'b0 && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 200, 1);
    tick();
  endtask

  task automatic check_frame(input string name, input int u, input logic [9:0] pat);
    for (int k = 1; k <= 41; k++) begin
      if (k > 1) tick();
      if (k <= 40) chk(name, tx_w[u], pat[(k - 1) / CPB]);
      if (k == 39) chk({name, "_ready_early"}, rdy_w[u], 0);
      if (k == 40) chk({name, "_ready_last"}, rdy_w[u], 1);
      if (k == 41) chk({name, "_busy_end"}, bsy_w[u], 0);
    end
  endtask

  task automatic start_word(input int u, input logic [8:0] d);
    valid_w[u] = 1'b1;
    din[u]     = d;
    tick();
    valid_w[u] = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    reset   = 1'b1;
    valid_w = 4'b0;
    for (int u = 0; u < 4; u++) din[u] = 9'h0;
    repeat (3) tick();
    for (int u = 0; u < 4; u++) chk($sformatf("reset_state[%0d]", u), st_w[u], ST_IDLE);
    reset = 1'b0;
    tick();

    // 8N1 0x55: alternating line, ready only on the 40th clk.
    start_word(0, 9'h055);
    pat = 10'b1010101010;
    check_frame("t1_8n1_55", 0, pat);
    wait_idle();

    // 0x03 with even and odd parity: 11-bit, 44-clk frames.
    valid_w[1] = 1'b1; din[1] = 9'h003;
    valid_w[2] = 1'b1; din[2] = 9'h003;
    tick();
    valid_w[1] = 1'b0; valid_w[2] = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) tick();
      if (k >= 37 && k <= 40) begin
        chk("t2_even_parity", tx_w[1], 0);
        chk("t2_odd_parity", tx_w[2], 1);
      end
      if (k == 43) chk("t2_ready_early", rdy_w[1], 0);
      if (k == 44) chk("t2_ready_last", rdy_w[2], 1);
      if (k == 45) chk("t2_busy_end", bsy_w[1], 0);
    end
    wait_idle();

    // Back-to-back 0xA5 then 0x3C with i_valid held high.
    valid_w[0] = 1'b1;
    din[0]     = 9'h0A5;
    tick();
    din[0] = 9'h03C;
    for (int k = 2; k <= 44; k++) begin
      tick();
      if (k == 40) chk("t3_ready_last", rdy_w[0], 1);
      if (k == 41) valid_w[0] = 1'b0;
      if (k >= 41) chk("t3_second_start", tx_w[0], 0);
      if (k == 41) chk("t3_busy_kept", bsy_w[0], 1);
    end
    wait_idle();

    // 7N2 0x7F with i_data scrambled after accept.
    start_word(3, 9'h07F);
    pat = 10'b1111111110;
    for (int k = 1; k <= 41; k++) begin
      if (k > 1) tick();
      din[3] = 9'($urandom_range(0, 511));
      if (k <= 40) chk("t4_7n2_7f", tx_w[3], pat[(k - 1) / CPB]);
      if (k == 40) chk("t4_ready_last", rdy_w[3], 1);
      if (k == 41) chk("t4_busy_end", bsy_w[3], 0);
    end
    wait_idle();

    // Reset at clk 17 of a frame (d3 of 0x55 is on the line), then a clean 0x81.
    start_word(0, 9'h055);
    repeat (16) tick();
    chk("t5_tx_before_reset", tx_w[0], 0);
    reset = 1'b1;
    #1;
    chk("t5_tx_async", tx_w[0], 1);
    chk("t5_ready_async", rdy_w[0], 1);
    chk("t5_busy_async", bsy_w[0], 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    start_word(0, 9'h081);
    pat = 10'b1100000010;
    check_frame("t5_8n1_81", 0, pat);
    wait_idle();

    // i_valid pulsed mid-frame with ready low: the word must be dropped.
    start_word(0, 9'h012);
    for (int k = 2; k <= 41; k++) begin
      tick();
      if (k == 10) begin
        valid_w[0] = 1'b1;
        din[0]     = 9'h0FF;
      end
      if (k == 11) valid_w[0] = 1'b0;
      if (k == 11) chk("t6_ready_low", rdy_w[0], 0);
      if (k == 41) chk("t6_busy_end", bsy_w[0], 0);
    end
    wait_idle();

    // Random traffic on all four configurations.
    for (int n = 0; n < 600; n++) begin
      for (int u = 0; u < 4; u++) begin
        valid_w[u] = ($urandom_range(0, 2) == 0);
        din[u]     = 9'($urandom_range(0, 511));
      end
      tick();
    end
    valid_w = 4'b0;
    wait_idle();
    repeat (4) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("decoder_idle", dec_on, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
